// File: rtl/rr_timeout_arbiter.sv
// Four-requester round-robin arbiter with registered one-hot grants, a dead cycle between owners
// and a bounded hold time. Optional macro ARB_LOCK_EN adds a lock input that suspends the timeout.
module rr_timeout_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       req0,
  input  logic       req1,
  input  logic       req2,
  input  logic       req3,
`ifdef ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic       grant0,
  output logic       grant1,
  output logic       grant2,
  output logic       grant3,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {StIdle = 2'd0, StGrant = 2'd1, StGap = 2'd2} state_e;

  state_e           state_q;
  logic [1:0]       ptr_q;
  logic [1:0]       owner_q;
  logic [CNT_W-1:0] hold_q;
  logic [3:0]       grant_q;
  logic [1:0]       id_q;
  logic             busy_q;
  logic             timeout_q;

  logic [3:0] req_vec;
  logic       win_found;
  logic [1:0] win_idx;
  logic [1:0] idx;
  logic       hold_last;
  logic       lock_hold;

  assign req_vec   = {req3, req2, req1, req0};
  assign hold_last = (hold_q == CNT_W'(MAX_HOLD - 1));

`ifdef ARB_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 2'd0;
    idx       = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr_q + i[1:0];
      if (req_vec[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      ptr_q     <= 2'd0;
      owner_q   <= 2'd0;
      hold_q    <= '0;
      grant_q   <= 4'd0;
      id_q      <= 2'd0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle, StGap: begin
          if (win_found) begin
            state_q <= StGrant;
            owner_q <= win_idx;
            hold_q  <= '0;
            grant_q <= 4'b0001 << win_idx;
            id_q    <= win_idx;
            busy_q  <= 1'b1;
          end else begin
            state_q <= StIdle;
            grant_q <= 4'd0;
            id_q    <= 2'd0;
            busy_q  <= 1'b0;
          end
        end
        StGrant: begin
          // Release takes precedence over an expiry on the same edge.
          if (!req_vec[owner_q]) begin
            state_q <= StGap;
            ptr_q   <= owner_q + 2'd1;
            grant_q <= 4'd0;
            id_q    <= 2'd0;
            busy_q  <= 1'b0;
          end else if (hold_last && !lock_hold) begin
            state_q   <= StGap;
            ptr_q     <= owner_q + 2'd1;
            grant_q   <= 4'd0;
            id_q      <= 2'd0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b1;
          end else if (!hold_last) begin
            hold_q <= hold_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          grant_q <= 4'd0;
          id_q    <= 2'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign grant0   = grant_q[0];
  assign grant1   = grant_q[1];
  assign grant2   = grant_q[2];
  assign grant3   = grant_q[3];
  assign grant_id = id_q;
  assign busy     = busy_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_rr_timeout_arbiter.sv
// Scoreboard bench for rr_timeout_arbiter (MAX_HOLD=4): the driver queues hand-computed outputs,
// a monitor pops one entry after each rising edge and compares.
module tb_rr_timeout_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_r;
  logic       lock_r;
  logic       g0, g1, g2, g3;
  logic [1:0] gid;
  logic       busy_o;
  logic       to_o;

  logic [4:0] sb[$];
  string      phase;
  int         n_checks;
  int         n_fail;

  rr_timeout_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .CLK     (clk),
    .RESET_N (rst_n),
    .req0    (req_r[0]),
    .req1    (req_r[1]),
    .req2    (req_r[2]),
    .req3    (req_r[3]),
`ifdef ARB_LOCK_EN
    .lock    (lock_r),
`endif
    .grant0  (g0),
    .grant1  (g1),
    .grant2  (g2),
    .grant3  (g3),
    .grant_id(gid),
    .busy    (busy_o),
    .timeout (to_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] eg, input logic et);
    logic [3:0] ag;
    logic [1:0] eid;
    logic       eb;
    ag  = {g3, g2, g1, g0};
    eb  = |eg;
    eid = 2'd0;
    for (int i = 0; i < 4; i++) if (eg[i]) eid = i[1:0];
    n_checks++;
    if (ag !== eg || gid !== eid || busy_o !== eb || to_o !== et) begin
      n_fail++;
      $display("FAIL %s @%0t: got grant=%b id=%0d busy=%b timeout=%b, want grant=%b id=%0d busy=%b timeout=%b",
               name, $time, ag, gid, busy_o, to_o, eg, eid, eb, et);
    end
  endtask

  // Inputs applied on the falling edge; the entry describes outputs after the next rising edge.
  task automatic cyc(input logic [3:0] r, input logic [3:0] g, input logic t);
    @(negedge clk);
    req_r = r;
    sb.push_back({g, t});
  endtask

  initial begin : monitor
    logic [4:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(phase, e[4:1], e[0]);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : driver
    n_checks = 0;
    n_fail   = 0;
    req_r    = 4'd0;
    lock_r   = 1'b0;
    rst_n    = 1'b0;
    phase    = "reset";
    #3;
    check("reset_state", 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // All four request: 0,1,2,3,0 with a timed-out gap between owners.
    phase = "reset_priority";
    for (int k = 0; k < 5; k++) begin
      repeat (4) cyc(4'b1111, 4'b0001 << (k % 4), 1'b0);
      if (k < 4) cyc(4'b1111, 4'b0000, 1'b1);
    end
    phase = "release_at_limit";
    cyc(4'b0000, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);

    phase = "voluntary_release";
    repeat (3) cyc(4'b0100, 4'b0100, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);

    // ptr is 3 after the req2 grant.
    phase = "fairness";
    repeat (4) cyc(4'b1001, 4'b1000, 1'b0);
    cyc(4'b1001, 4'b0000, 1'b1);
    repeat (4) cyc(4'b1001, 4'b0001, 1'b0);
    cyc(4'b1001, 4'b0000, 1'b1);
    repeat (4) cyc(4'b1001, 4'b1000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);

    phase = "timeout";
    for (int k = 0; k < 3; k++) begin
      repeat (4) cyc(4'b0010, 4'b0010, 1'b0);
      if (k < 2) cyc(4'b0010, 4'b0000, 1'b1);
    end
    cyc(4'b0000, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);

    // ptr is 2 here; after the reset it must be back at 0 so req1 beats req2.
    phase = "async_reset";
    repeat (2) cyc(4'b0010, 4'b0010, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req_r = 4'b0110;
    #1;
    check("async_reset_drop", 4'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back({4'b0010, 1'b0});
    repeat (3) cyc(4'b0110, 4'b0010, 1'b0);
    cyc(4'b0110, 4'b0000, 1'b1);
    cyc(4'b0110, 4'b0100, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);

`ifdef ARB_LOCK_EN
    phase  = "lock";
    lock_r = 1'b1;
    repeat (10) cyc(4'b0001, 4'b0001, 1'b0);
    @(negedge clk);
    lock_r = 1'b0;
    req_r  = 4'b0001;
    sb.push_back({4'b0000, 1'b1});
    cyc(4'b0001, 4'b0001, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b0);
`endif

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
